// File: rtl/fir_lane_mac.sv
// Single-lane FIR multiply-accumulate over a 512-entry sample history.
// Optional FIR_ROUND_EN: round-half-up before the output shift (default: truncate).
module fir_lane_mac #(
    parameter int gen_param_addr = 1,
    parameter int acw            = 30
) (
    input  logic        clk1,
    input  logic        rst,
    input  logic        pcm_in_wr,
    input  logic [15:0] pcm_in,
    input  logic [8:0]  pcm_in_address,
    input  logic        fir_start,
    input  logic [7:0]  tap_len,
    input  logic [3:0]  pcm_out_shift,
    input  logic [31:0] param_q,
    output logic [7:0]  param_addr,
    output logic [15:0] pcm_out,
    output logic        busy,
    output logic        done
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t state, state_nx;

    logic [15:0]           hist_mem [512];
    logic signed [15:0]    hist_q;
    logic [8:0]            base;
    logic [8:0]            rd_addr;
    logic [8:0]            k;
    logic [7:0]            len;
    logic [3:0]            shift;
    logic                  issue;
    logic                  finish;
    logic                  rd_v;
    logic                  prod_v;
    logic signed [31:0]    prod;
    logic signed [acw-1:0] acc;
    logic signed [acw-1:0] prod_ext;
    logic signed [acw-1:0] rnd;
    logic signed [acw-1:0] shifted;
    logic [15:0]           sat;
    logic                  unused_param_hi;

    assign unused_param_hi = ^param_q[31:16];

    assign busy    = (state == RUN);
    assign issue   = busy && (k < {1'b0, len});
    // Last product lands in acc two edges after the last issue; result one edge later.
    assign finish  = busy && (k == ({1'b0, len} + 9'd2));
    assign rd_addr = base - k;

    generate
        if (gen_param_addr != 0) begin : g_addr
            assign param_addr = issue ? k[7:0] : '0;
        end else begin : g_no_addr
            assign param_addr = '0;
        end

        if (acw > 32) begin : g_ext
            assign prod_ext = {{(acw-32){prod[31]}}, prod};
        end else if (acw == 32) begin : g_same
            assign prod_ext = prod;
        end else begin : g_trunc
            assign prod_ext = prod[acw-1:0];
        end
    endgenerate

    always_ff @(posedge clk1) begin
        if (pcm_in_wr) begin
            hist_mem[pcm_in_address] <= pcm_in;
        end
        hist_q <= hist_mem[rd_addr];
    end

    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (fir_start) state_nx = RUN;
            RUN:     if (!fir_start && finish) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        rnd = acc;
`ifdef FIR_ROUND_EN
        if (shift != '0) begin
            rnd = acc + ({{(acw-1){1'b0}}, 1'b1} << (shift - 4'd1));
        end
`endif
        shifted = rnd >>> shift;
        if (shifted[acw-1:15] == {(acw-15){shifted[acw-1]}}) begin
            sat = shifted[15:0];
        end else if (shifted[acw-1]) begin
            sat = 16'h8000;
        end else begin
            sat = 16'h7fff;
        end
    end

    // A restart flushes the pipeline so no product of the aborted job reaches acc.
    always_ff @(posedge clk1 or negedge rst) begin
        if (!rst) begin
            base    <= '0;
            len     <= '0;
            shift   <= '0;
            k       <= '0;
            rd_v    <= 1'b0;
            prod_v  <= 1'b0;
            prod    <= '0;
            acc     <= '0;
            pcm_out <= '0;
            done    <= 1'b0;
        end else begin
            done   <= 1'b0;
            rd_v   <= issue;
            prod_v <= rd_v;
            prod   <= hist_q * $signed(param_q[15:0]);
            if (prod_v) begin
                acc <= acc + prod_ext;
            end
            if (busy) begin
                k <= k + 9'd1;
            end
            if (fir_start) begin
                base   <= pcm_in_address;
                len    <= tap_len;
                shift  <= pcm_out_shift;
                k      <= '0;
                acc    <= '0;
                rd_v   <= 1'b0;
                prod_v <= 1'b0;
            end else if (finish) begin
                pcm_out <= sat;
                done    <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fir_lane_mac.sv
// Scoreboard bench for fir_lane_mac: directed jobs push expected results, a monitor checks on done.
module tb_fir_lane_mac;

    localparam int ACW = 40;

    logic        clk1 = 1'b0;
    logic        rst = 1'b0;
    logic        pcm_in_wr = 1'b0;
    logic [15:0] pcm_in = '0;
    logic [8:0]  pcm_in_address = '0;
    logic        fir_start = 1'b0;
    logic [7:0]  tap_len = '0;
    logic [3:0]  pcm_out_shift = '0;
    logic [31:0] param_q;
    logic [7:0]  param_addr, param_addr0;
    logic [15:0] pcm_out, pcm_out0;
    logic        busy, busy0, done, done0;

    logic [15:0] coef [256];
    int unsigned cyc = 0;
    int          tests = 0;
    int          fails = 0;
    logic        pa0_nonzero = 1'b0;
    logic [7:0]  pa_max = '0;

    typedef struct {
        logic [15:0] val;
        int unsigned due;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t sb0[$];
    exp_t mon_e;
    exp_t mon_e0;

    fir_lane_mac #(.gen_param_addr(1), .acw(ACW)) dut (
        .clk1(clk1), .rst(rst), .pcm_in_wr(pcm_in_wr), .pcm_in(pcm_in),
        .pcm_in_address(pcm_in_address), .fir_start(fir_start), .tap_len(tap_len),
        .pcm_out_shift(pcm_out_shift), .param_q(param_q), .param_addr(param_addr),
        .pcm_out(pcm_out), .busy(busy), .done(done)
    );

    fir_lane_mac #(.gen_param_addr(0), .acw(ACW)) dut0 (
        .clk1(clk1), .rst(rst), .pcm_in_wr(pcm_in_wr), .pcm_in(pcm_in),
        .pcm_in_address(pcm_in_address), .fir_start(fir_start), .tap_len(tap_len),
        .pcm_out_shift(pcm_out_shift), .param_q(param_q), .param_addr(param_addr0),
        .pcm_out(pcm_out0), .busy(busy0), .done(done0)
    );

    always #5 clk1 = ~clk1;

    // Synchronous coefficient RAM model, one cycle of read latency.
    always @(posedge clk1) begin
        cyc     <= cyc + 1;
        param_q <= {16'h0000, coef[param_addr]};
    end

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, $signed(act), $signed(req));
        end
    endtask

    task automatic check_u(input string name, input int unsigned act, input int unsigned req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    always @(negedge clk1) begin
        if (param_addr0 != '0) pa0_nonzero <= 1'b1;
        if (busy && param_addr > pa_max) pa_max <= param_addr;
        if (done) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done: done at cycle %0d, required no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                check16({mon_e.name, "_value"}, pcm_out, mon_e.val);
                check_u({mon_e.name, "_latency"}, cyc, mon_e.due);
            end
        end
        if (done0) begin
            if (sb0.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_done_gen0: done at cycle %0d, required no done", cyc);
            end else begin
                mon_e0 = sb0.pop_front();
                check16({mon_e0.name, "_gen0_value"}, pcm_out0, mon_e0.val);
            end
        end
    end

    task automatic wr_hist(input logic [8:0] a, input logic [15:0] v);
        @(negedge clk1);
        pcm_in_wr      = 1'b1;
        pcm_in_address = a;
        pcm_in         = v;
        @(posedge clk1);
        #1 pcm_in_wr = 1'b0;
    endtask

    task automatic start_job(input logic [8:0] b, input logic [7:0] l, input logic [3:0] s,
                             output int unsigned start_cyc);
        @(negedge clk1);
        fir_start      = 1'b1;
        pcm_in_address = b;
        tap_len        = l;
        pcm_out_shift  = s;
        @(posedge clk1);
        #1;
        fir_start     = 1'b0;
        start_cyc     = cyc;
        tap_len       = 8'hff;
        pcm_out_shift = 4'hf;
    endtask

    task automatic push_exp(input logic [15:0] v, input int unsigned due, input string name);
        exp_t e;
        e.val  = v;
        e.due  = due;
        e.name = name;
        sb.push_back(e);
        sb0.push_back(e);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((sb.size() != 0 || sb0.size() != 0) && n < 300) begin
            @(negedge clk1);
            n++;
        end
        if (sb.size() != 0 || sb0.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: no done within %0d cycles, required done", name, n);
            sb.delete();
            sb0.delete();
        end
        repeat (3) @(negedge clk1);
    endtask

    task automatic run_job(input logic [8:0] b, input logic [7:0] l, input logic [3:0] s,
                           input logic [15:0] v, input string name);
        int unsigned sc;
        start_job(b, l, s, sc);
        push_exp(v, sc + l + 3, name);
        wait_drain(name);
    endtask

    initial begin
        int unsigned sc;
        logic [15:0] exp_p3, exp_n7, exp_s4;
`ifdef FIR_ROUND_EN
        exp_p3 = 16'd4;
        exp_n7 = 16'hfffd;
        exp_s4 = 16'd188;
`else
        exp_p3 = 16'd3;
        exp_n7 = 16'hfffc;
        exp_s4 = 16'd187;
`endif
        for (int i = 0; i < 256; i++) coef[i] = 16'(i + 1);

        repeat (3) @(posedge clk1);
        #2;
        check16("reset_pcm_out", pcm_out, 16'd0);
        check_u("reset_busy", busy, 0);
        check_u("reset_done", done, 0);
        check_u("reset_param_addr", param_addr, 0);
        @(negedge clk1);
        rst = 1'b1;

        for (int a = 0; a < 512; a++) wr_hist(9'(a), 16'd0);

        wr_hist(9'd5, 16'd1000);
        run_job(9'd7, 8'd4, 4'd0, 16'd3000, "impulse");

        start_job(9'd7, 8'd10, 4'd0, sc);
        @(negedge clk1);
        start_job(9'd7, 8'd10, 4'd0, sc);
        push_exp(16'd3000, sc + 13, "restart");
        wait_drain("restart");

        run_job(9'd7, 8'd0, 4'd0, 16'd0, "zero_taps");

        for (int i = 0; i < 256; i++) coef[i] = 16'd1;
        wr_hist(9'd511, 16'd100);
        wr_hist(9'd0, 16'd200);
        wr_hist(9'd1, 16'd300);
        run_job(9'd1, 8'd3, 4'd0, 16'd600, "wrap");

        wr_hist(9'd30, 16'd7);
        run_job(9'd30, 8'd1, 4'd1, exp_p3, "shift_pos7");
        wr_hist(9'd30, 16'hfff9);
        run_job(9'd30, 8'd1, 4'd1, exp_n7, "shift_neg7");
        wr_hist(9'd30, 16'd3000);
        run_job(9'd30, 8'd1, 4'd4, exp_s4, "shift4");

        for (int i = 0; i < 256; i++) coef[i] = 16'd32767;
        for (int a = 13; a <= 20; a++) wr_hist(9'(a), 16'd32767);
        run_job(9'd20, 8'd8, 4'd0, 16'd32767, "sat_pos");
        for (int a = 13; a <= 20; a++) wr_hist(9'(a), 16'h8001);
        run_job(9'd20, 8'd8, 4'd0, 16'h8000, "sat_neg");

        start_job(9'd20, 8'd10, 4'd0, sc);
        repeat (3) @(posedge clk1);
        #2 rst = 1'b0;
        #1;
        check_u("async_reset_busy", busy, 0);
        check_u("async_reset_busy_gen0", busy0, 0);
        check_u("async_reset_done", done, 0);
        check16("async_reset_pcm_out", pcm_out, 16'd0);
        check_u("async_reset_param_addr", param_addr, 0);
        @(negedge clk1);
        rst = 1'b1;
        repeat (20) @(negedge clk1);

        run_job(9'd20, 8'd2, 4'd0, 16'h8000, "after_reset");

        check_u("gen0_param_addr_zero", pa0_nonzero, 0);
        check_u("param_addr_max", pa_max, 9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fir_lane_mac.md
Name: fir_lane_mac

Overview:
- Single-lane FIR engine for the ultrasound PCM path: keeps a 512-entry history of 16-bit input samples and, on each start strobe, computes one filtered output sample using a multiply-accumulate over tap_len taps.
- Coefficients come from an external synchronous coefficient RAM addressed by param_addr.
- Several lanes are instantiated in parallel by the multi-lane fir wrapper, which round-robins fir_start between them.

Parameters:
- gen_param_addr, 1: 1 = param_addr driven with the current tap index; 0 = param_addr held at 0 and the coefficient RAM streams coefficients itself.
- acw, 30: accumulator width in bits, signed; legal range 32..48 is not required, 30 is the default.

Ports:
- clk1  in  1  sole clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- pcm_in_wr  in  1  write pcm_in into the history buffer this cycle.
- pcm_in  in  16  signed input sample.
- pcm_in_address  in  9  history write address; the wrapper increments it per written sample.
- fir_start  in  1  start one output computation.
- tap_len  in  8  number of taps L.
- pcm_out_shift  in  4  arithmetic right shift applied to the accumulator.
- param_q  in  32  coefficient read data; signed coefficient in [15:0], [31:16] ignored.
- param_addr  out  8  coefficient address.
- pcm_out  out  16  last completed filtered sample (held).
- busy  out  1  computation in progress.
- done  out  1  one-cycle pulse when pcm_out updates.

Behaviour:
- Reset (rst=0, async): pcm_out=0, busy=0, done=0, param_addr=0, accumulator=0, tap counter=0. History RAM contents are not reset.
- History write: on a clk1 edge with pcm_in_wr=1, mem[pcm_in_address]=pcm_in. Writes are independent of busy.
- Start, cycle 0: on a clk1 edge with fir_start=1, latch base=pcm_in_address, clear the accumulator, set k=0, set busy=1. The sample written in the same cycle is x[n] at base.
- Issue, cycles 1..L:
  - read history at (base-k) mod 512, wrapping 0 to 511.
  - param_addr=k when gen_param_addr=1, else 0.
  - k increments each cycle.
- Pipeline:
  - Both RAM reads have 1-cycle latency.
  - The 16x16 signed product (32 bits) is registered.
  - The product is sign-extended or truncated to acw bits and added to the accumulator; accumulator overflow wraps modulo 2^acw.
- Result: the edge after the last accumulate, i.e. L+3 cycles after the fir_start edge:
  - pcm_out = saturate16(acc >>> pcm_out_shift), clamped to [-32768, 32767].
  - done=1 for one cycle, busy=0.
- Read-after-write: a history read of an address written on the preceding edge returns the new data.
- tap_len=0: no taps issued; pcm_out=0 and done pulses at cycle 3.
- fir_start while busy: the current computation is aborted with no done, and a new one restarts from cycle 0 using the new base.
- tap_len and pcm_out_shift are sampled at fir_start and held for the whole computation.
- param_addr returns to 0 when idle.

Optional Feature:
- FIR_ROUND_EN defined: before the shift, add 2^(pcm_out_shift-1) to the accumulator (no add when shift=0), giving round-half-up.
- Undefined: plain truncating arithmetic shift.

Test Plan:
- Impulse:
  - Stimulus: write 1000 at address 5, zeros elsewhere; coefficients c[k]=k+1; fir_start with pcm_in_address=7, L=4, shift=0.
  - Required response: pcm_out=3000 (tap k=2), done exactly 7 cycles after start.
- Wrap:
  - Stimulus: samples 100/200/300 at addresses 511/0/1; base=1, L=3, all coefficients 1.
  - Required response: pcm_out=600.
- Saturation:
  - Stimulus: all samples 32767, coefficients 32767, L=8, shift=0.
  - Required response: pcm_out=32767.
  - Stimulus: negative mirror of the above.
  - Required response: pcm_out=-32768.
- Shift and round:
  - Stimulus: accumulator result 7, shift=1.
  - Required response: pcm_out=3 without FIR_ROUND_EN, 4 with it.
- Restart and reset:
  - Stimulus: fir_start again at cycle 2 of an L=10 job.
  - Required response: only one done, 13 cycles after the second start.
  - Stimulus: assert rst mid-job.
  - Required response: busy, done and pcm_out go to 0 immediately, without waiting for a clock edge.
- gen_param_addr=0:
  - Required response: param_addr stays 0 for the entire job.
